hc_down_timer: RTL and testbench
================================

Name: hc_down_timer

Overview:
- Presettable down-counting timer; the count-down counterpart of the team's 74HC161-style synchronous up counter.
- Loads a start value, decrements on enabled clocks, and flags expiry with a one-cycle DONE pulse and a TC level.
- Supports one-shot and auto-reload (periodic) modes.
- Sits beside the up counter in the timing/sequencing logic, generating delays and periodic ticks for control FSMs.

Parameters:
- WIDTH, 4, counter and load-data width in bits (legal range 2..16).

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- MR  input  1  master reset; asynchronous, active-high.
- PE  input  1  parallel load enable, active-low (same polarity as the up counter's PE).
- D  input  WIDTH  load value; also captured as the reload value.
- CEP  input  1  count enable, parallel; active-high.
- CET  input  1  count enable, trickle; active-high.
- START  input  1  start request; sampled only in IDLE.
- STOP  input  1  abort request; sampled only in RUN.
- AUTO  input  1  mode; 1 = auto-reload, 0 = one-shot; sampled at each expiry.
- Q  output  WIDTH  current count (registered).
- TC  output  1  registered; high exactly while Q == 0.
- BUSY  output  1  registered; high while in state RUN.
- DONE  output  1  registered one-cycle pulse on expiry.

Behaviour:
- Async reset (MR=1), applies immediately:
  - Q=0, internal RELOAD=0, state=IDLE.
  - TC=1 (Q is 0), BUSY=0, DONE=0.
  - Reset mid-count aborts with no DONE.
- Synchronous priority, highest first: PE low > STOP > START > count.
- DONE defaults to 0 every cycle unless set below.
- PE low, any state:
  - Q<=D, RELOAD<=D, state<=IDLE, DONE<=0.
  - Aborts a run; no DONE is produced.
- State IDLE:
  - Q holds; CEP and CET are ignored.
  - START=1 and Q!=0: state<=RUN; the first decrement can occur on the next edge.
  - START=1 and Q==0: stay IDLE; DONE<=1 on the next edge (zero-length timer).
- State RUN:
  - STOP=1: state<=IDLE, Q holds, no DONE. STOP wins over a simultaneous expiry.
  - CEP=0 or CET=0: Q holds, no state change.
  - CEP=CET=1 and Q>1: Q<=Q-1.
  - CEP=CET=1 and Q==1 (expiry): DONE<=1, then:
    - AUTO=0: Q<=0, state<=IDLE.
    - AUTO=1 and RELOAD!=0: Q<=RELOAD, stay RUN.
    - AUTO=1 and RELOAD==0: treated as AUTO=0.
- Period timing:
  - One-shot from load value N: DONE asserts on the edge after N enabled cycles in RUN.
  - Auto-reload: DONE every N enabled cycles; Q never shows 0.
- Wrap-around: Q never decrements below 0; no underflow from 0 to all-ones.
- TC and BUSY are registered from next-state values, so they align with Q and state on the same cycle.
- START asserted while in RUN is ignored.
- STOP asserted while in IDLE is ignored.
- After STOP, Q keeps its partial value; a later START resumes from that value.
- Arithmetic: unsigned, WIDTH bits; RELOAD is WIDTH bits.

Test Plan:
- Reset: MR=1 pulsed mid-RUN with Q=5 -> immediately Q=0, TC=1, BUSY=0, DONE=0; remains IDLE after MR falls.
- One-shot: PE low with D=3, then START, CEP=CET=1, AUTO=0 -> Q reads 3,2,1,0 on successive cycles; DONE high for one cycle coincident with Q=0; TC=1; BUSY falls on the same cycle.
- Auto-reload: D=4, AUTO=1, enables held high for 12 cycles -> Q sequence 4,3,2,1,4,3,2,1,...; DONE pulses every 4 cycles (3 pulses total); BUSY stays 1.
- Enable gating: D=5, RUN with CET toggled 1,0,1,0 -> Q decrements only on CET=1 cycles; expiry takes 5 enabled cycles; CEP=0 likewise freezes Q.
- Priority: in RUN at Q=1 with enables high, assert STOP -> Q stays 1, state IDLE, no DONE. Next, PE low with D=9 simultaneously with START -> Q=9, state IDLE.
- Zero edge cases: load D=0 then START -> DONE one cycle, BUSY never 1. With WIDTH=4 and D=15 auto-reload -> no underflow; Q reads 15..1 repeatedly.

Source files
------------

// File: rtl/hc_down_timer.sv
// hc_down_timer: presettable down-counting timer with one-shot and
// auto-reload modes. Loads a start value, decrements on enabled clocks,
// and flags expiry with a one-cycle DONE pulse and a TC level.
module hc_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             PE,
  input  logic [WIDTH-1:0] D,
  input  logic             CEP,
  input  logic             CET,
  input  logic             START,
  input  logic             STOP,
  input  logic             AUTO,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
  logic             done_next;
  logic             enabled;

  assign enabled = CEP & CET;

  // State, count and flag registers; TC/BUSY are registered from the
  // next-state values so they line up with Q and state on the same cycle.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state  <= IDLE;
      count  <= ZERO;
      reload <= ZERO;
      DONE   <= 1'b0;
      TC     <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      DONE   <= done_next;
      TC     <= (count_next == ZERO);
      BUSY   <= (state_next == RUN);
    end
  end

  // Next-state logic; priority is load > stop > start > count.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;
    if (!PE) begin
      // Load aborts any run without producing DONE.
      count_next  = D;
      reload_next = D;
      state_next  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            if (count != ZERO) begin
              state_next = RUN;
            end else begin
              // Zero-length timer: expire immediately, never become busy.
              done_next = 1'b1;
            end
          end
        end
        RUN: begin
          if (STOP) begin
            // Abort keeps the partial count so a later START resumes.
            state_next = IDLE;
          end else if (enabled) begin
            if (count > ONE) begin
              count_next = count - ONE;
            end else if (count == ONE) begin
              done_next = 1'b1;
              if (AUTO && (reload != ZERO)) begin
                count_next = reload;
              end else begin
                count_next = ZERO;
                state_next = IDLE;
              end
            end else begin
              // Count of zero cannot normally be running; fall back to IDLE
              // rather than wrap to all-ones.
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign Q = count;

endmodule

// File: tb/tb_hc_down_timer.sv
// Directed testbench for hc_down_timer (WIDTH = 4).
module tb_hc_down_timer;

  localparam int WIDTH = 4;

  logic             CP;
  logic             MR;
  logic             PE;
  logic [WIDTH-1:0] D;
  logic             CEP;
  logic             CET;
  logic             START;
  logic             STOP;
  logic             AUTO;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             BUSY;
  logic             DONE;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  hc_down_timer #(.WIDTH(WIDTH)) dut (
    .CP(CP), .MR(MR), .PE(PE), .D(D), .CEP(CEP), .CET(CET),
    .START(START), .STOP(STOP), .AUTO(AUTO),
    .Q(Q), .TC(TC), .BUSY(BUSY), .DONE(DONE)
  );

  // 10 ns clock
  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk_all(input string tag, input int q, input int tc, input int busy, input int done);
    chk({tag, ".Q"}, 32'(Q), q);
    chk({tag, ".TC"}, 32'(TC), tc);
    chk({tag, ".BUSY"}, 32'(BUSY), busy);
    chk({tag, ".DONE"}, 32'(DONE), done);
  endtask

  initial begin
    MR = 1'b1; PE = 1'b1; D = '0; CEP = 1'b0; CET = 1'b0;
    START = 1'b0; STOP = 1'b0; AUTO = 1'b0;
    tick();
    chk_all("reset", 0, 1, 0, 0);
    MR = 1'b0;
    tick();
    chk_all("post_reset", 0, 1, 0, 0);

    // One-shot from 3
    PE = 1'b0; D = 4'd3;
    tick();
    chk_all("os_load", 3, 0, 0, 0);
    PE = 1'b1; START = 1'b1; CEP = 1'b1; CET = 1'b1; AUTO = 1'b0;
    tick();
    chk_all("os_start", 3, 0, 1, 0);
    START = 1'b0;
    tick();
    chk_all("os_q2", 2, 0, 1, 0);
    tick();
    chk_all("os_q1", 1, 0, 1, 0);
    tick();
    chk_all("os_expire", 0, 1, 0, 1);
    tick();
    chk_all("os_after", 0, 1, 0, 0);

    // Auto-reload from 4 for 12 enabled cycles
    PE = 1'b0; D = 4'd4; AUTO = 1'b1;
    tick();
    PE = 1'b1; START = 1'b1;
    tick();
    chk_all("ar_start", 4, 0, 1, 0);
    START = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all("ar_seq", 4 - ((i + 1) % 4), 0, 1, ((i + 1) % 4 == 0) ? 1 : 0);
      if (DONE) pulses++;
    end
    chk("ar_pulses", 32'(pulses), 3);
    STOP = 1'b1;
    tick();
    chk_all("ar_stop", 4, 0, 0, 0);
    STOP = 1'b0;

    // Enable gating from 5
    PE = 1'b0; D = 4'd5; AUTO = 1'b0;
    tick();
    PE = 1'b1; START = 1'b1; CEP = 1'b1; CET = 1'b1;
    tick();
    chk_all("eg_start", 5, 0, 1, 0);
    START = 1'b0;
    tick();
    chk_all("eg_cet1a", 4, 0, 1, 0);
    CET = 1'b0;
    START = 1'b1;  // START while running has no effect
    tick();
    chk_all("eg_cet0a", 4, 0, 1, 0);
    START = 1'b0;
    CET = 1'b1;
    tick();
    chk_all("eg_cet1b", 3, 0, 1, 0);
    CET = 1'b0;
    tick();
    chk_all("eg_cet0b", 3, 0, 1, 0);
    CEP = 1'b0; CET = 1'b1;
    tick();
    chk_all("eg_cep0", 3, 0, 1, 0);
    CEP = 1'b1;
    tick();
    chk_all("eg_q2", 2, 0, 1, 0);
    tick();
    chk_all("eg_q1", 1, 0, 1, 0);
    tick();
    chk_all("eg_expire", 0, 1, 0, 1);

    // Priority: STOP beats expiry, then resume, then load beats START
    PE = 1'b0; D = 4'd2;
    tick();
    PE = 1'b1; START = 1'b1;
    tick();
    chk_all("pr_start", 2, 0, 1, 0);
    START = 1'b0;
    tick();
    chk_all("pr_q1", 1, 0, 1, 0);
    STOP = 1'b1;
    tick();
    chk_all("pr_stop", 1, 0, 0, 0);
    tick();
    chk_all("pr_stop_idle", 1, 0, 0, 0);
    STOP = 1'b0; START = 1'b1;
    tick();
    chk_all("pr_resume", 1, 0, 1, 0);
    START = 1'b0;
    tick();
    chk_all("pr_resume_exp", 0, 1, 0, 1);
    PE = 1'b0; D = 4'd9; START = 1'b1;
    tick();
    chk_all("pr_load_start", 9, 0, 0, 0);
    PE = 1'b1; START = 1'b0;
    tick();
    chk_all("pr_idle_hold", 9, 0, 0, 0);

    // Zero-length timer
    PE = 1'b0; D = 4'd0;
    tick();
    chk_all("z_load", 0, 1, 0, 0);
    PE = 1'b1; START = 1'b1;
    tick();
    chk_all("z_start", 0, 1, 0, 1);
    START = 1'b0;
    tick();
    chk_all("z_after", 0, 1, 0, 0);

    // Full-scale auto-reload from 15: no underflow
    PE = 1'b0; D = 4'd15; AUTO = 1'b1;
    tick();
    PE = 1'b1; START = 1'b1;
    tick();
    chk_all("fs_start", 15, 0, 1, 0);
    START = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_all("fs_seq", 15 - ((i + 1) % 15), 0, 1, ((i + 1) % 15 == 0) ? 1 : 0);
    end
    chk("fs_q5", 32'(Q), 5);

    // Asynchronous reset mid-run at Q=5
    #2;
    MR = 1'b1;
    #1;
    chk_all("mr_async", 0, 1, 0, 0);
    #1;
    MR = 1'b0;
    tick();
    chk_all("mr_idle", 0, 1, 0, 0);
    tick();
    chk_all("mr_idle2", 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
